// File: rtl/uart_command_pkg.sv
// Shared definitions for the UART command parser.
//   - Opcode byte values that start each command frame.
//   - Register-file addresses used for the two ALU operands.
//   - Parser FSM state encoding.
package uart_command_pkg;

  localparam logic [7:0] CMD_REG_WRITE       = 8'hAA;  // AA, addr, data
  localparam logic [7:0] CMD_REG_READ        = 8'hBB;  // BB, addr
  localparam logic [7:0] CMD_ALU_OPERANDS    = 8'hCC;  // CC, A, B, func
  localparam logic [7:0] CMD_ALU_NO_OPERANDS = 8'hDD;  // DD, func

  localparam int OPERAND_A_ADDRESS = 0;
  localparam int OPERAND_B_ADDRESS = 1;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    ALU_A,
    ALU_B,
    ALU_FUNC,
    ALU_FUNC_NOP
  } parser_state_e;

endpackage

// File: rtl/uart_frame_timeout_counter.sv
// Inter-byte timeout counter for one command frame.
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   clear_i      a byte arrived: restart the count (wins over everything)
//   enable_i     a frame is in progress: count this cycle
//   expired_o    the count reaches TIMEOUT_CYCLES at the coming clk edge
// The count is cleared to 0 by the byte, so it reaches TIMEOUT_CYCLES
// exactly TIMEOUT_CYCLES edges after the edge that sampled the byte.
// A TIMEOUT_CYCLES of 0 disables expiry. The count saturates.
module uart_frame_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int COUNT_WIDTH = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [COUNT_WIDTH-1:0] LIMIT      = COUNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [COUNT_WIDTH-1:0] LAST_COUNT =
    COUNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit ENABLED = (TIMEOUT_CYCLES > 0);

  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LIMIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A byte in the expiry cycle clears the count instead of expiring it.
  assign expired_o = ENABLED && enable_i && !clear_i && (count_q >= LAST_COUNT);

endmodule

// File: rtl/uart_rx_command_parser.sv
// UART command frame parser.
// Consumes the receiver's per-byte output and turns complete frames into
// single-cycle register-file and ALU strobes. Errored, malformed or stalled
// frames are discarded and reported with a frame_dropped pulse.
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   rx_data_valid       one-cycle byte strobe from the receiver
//   rx_data             received byte
//   rx_parity_error     qualifies rx_data_valid
//   rx_frame_error      qualifies rx_data_valid
//   reg_write_enable    one-cycle register write strobe
//   reg_read_enable     one-cycle register read strobe
//   reg_address         address for the read/write strobe (held between strobes)
//   reg_write_data      data for the write strobe (held between strobes)
//   alu_enable          one-cycle ALU start strobe
//   alu_function        function code for alu_enable (held between strobes)
//   frame_dropped       one-cycle strobe: the current frame was discarded
//   parser_busy         high whenever a frame is in progress
module uart_rx_command_parser
  import uart_command_pkg::*;
#(
  parameter int DATA_WIDTH         = 8,
  parameter int ADDRESS_WIDTH      = 4,
  parameter int ALU_FUNCTION_WIDTH = 4,
  parameter int TIMEOUT_CYCLES     = 4096
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_data_valid,
  input  logic [DATA_WIDTH-1:0]         rx_data,
  input  logic                          rx_parity_error,
  input  logic                          rx_frame_error,
  output logic                          reg_write_enable,
  output logic                          reg_read_enable,
  output logic [ADDRESS_WIDTH-1:0]      reg_address,
  output logic [DATA_WIDTH-1:0]         reg_write_data,
  output logic                          alu_enable,
  output logic [ALU_FUNCTION_WIDTH-1:0] alu_function,
  output logic                          frame_dropped,
  output logic                          parser_busy
);

  parser_state_e state_q, state_d;

  logic [ADDRESS_WIDTH-1:0]      wr_addr_q, wr_addr_d;
  logic                          reg_we_q, reg_we_d;
  logic                          reg_re_q, reg_re_d;
  logic [ADDRESS_WIDTH-1:0]      reg_addr_q, reg_addr_d;
  logic [DATA_WIDTH-1:0]         reg_wdata_q, reg_wdata_d;
  logic                          alu_en_q, alu_en_d;
  logic [ALU_FUNCTION_WIDTH-1:0] alu_func_q, alu_func_d;
  logic                          dropped_q, dropped_d;

  logic clean_byte;
  logic error_byte;
  logic addr_ok;
  logic busy;
  logic timeout_expired;
  logic drop;

  assign clean_byte = rx_data_valid && !rx_parity_error && !rx_frame_error;
  assign error_byte = rx_data_valid && (rx_parity_error || rx_frame_error);
  // Address bytes must not carry bits above the register-file address range.
  assign addr_ok    = ((rx_data >> ADDRESS_WIDTH) == '0);
  assign busy       = (state_q != IDLE);

  uart_frame_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (rx_data_valid),
    .enable_i (busy),
    .expired_o(timeout_expired)
  );

  // Next-state logic. Inside a frame an errored byte beats decoding, and any
  // arriving byte beats the timeout.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    state_d = state_q;
    drop    = 1'b0;
    if (state_q == IDLE) begin
      if (clean_byte) begin
        case (rx_data)
          DATA_WIDTH'(CMD_REG_WRITE):       state_d = WR_ADDR;
          DATA_WIDTH'(CMD_REG_READ):        state_d = RD_ADDR;
          DATA_WIDTH'(CMD_ALU_OPERANDS):    state_d = ALU_A;
          DATA_WIDTH'(CMD_ALU_NO_OPERANDS): state_d = ALU_FUNC_NOP;
          default:                          state_d = IDLE;
        endcase
      end
    end else if (error_byte) begin
      drop    = 1'b1;
      state_d = IDLE;
    end else if (clean_byte) begin
      case (state_q)
        WR_ADDR: begin
          if (addr_ok) begin
            state_d = WR_DATA;
          end else begin
            drop    = 1'b1;
            state_d = IDLE;
          end
        end
        RD_ADDR: begin
          drop    = !addr_ok;
          state_d = IDLE;
        end
        ALU_A:   state_d = ALU_B;
        ALU_B:   state_d = ALU_FUNC;
        default: state_d = IDLE;  // WR_DATA, ALU_FUNC, ALU_FUNC_NOP complete here
      endcase
    end else if (timeout_expired) begin
      drop    = 1'b1;
      state_d = IDLE;
    end
  end

  // Output logic: strobes default low, data outputs and the latched write
  // address hold their values unless this byte updates them.
  always_comb begin
    wr_addr_d   = wr_addr_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    alu_en_d    = 1'b0;
    alu_func_d  = alu_func_q;
    dropped_d   = drop;
    if (busy && clean_byte && !drop) begin
      case (state_q)
        WR_ADDR: wr_addr_d = rx_data[ADDRESS_WIDTH-1:0];
        WR_DATA: begin
          reg_we_d    = 1'b1;
          reg_addr_d  = wr_addr_q;
          reg_wdata_d = rx_data;
        end
        RD_ADDR: begin
          reg_re_d   = 1'b1;
          reg_addr_d = rx_data[ADDRESS_WIDTH-1:0];
        end
        ALU_A: begin
          reg_we_d    = 1'b1;
          reg_addr_d  = ADDRESS_WIDTH'(OPERAND_A_ADDRESS);
          reg_wdata_d = rx_data;
        end
        ALU_B: begin
          reg_we_d    = 1'b1;
          reg_addr_d  = ADDRESS_WIDTH'(OPERAND_B_ADDRESS);
          reg_wdata_d = rx_data;
        end
        ALU_FUNC, ALU_FUNC_NOP: begin
          alu_en_d   = 1'b1;
          alu_func_d = rx_data[ALU_FUNCTION_WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  // State and registered outputs. Reset clears everything, including the
  // held data outputs, and never produces a frame_dropped pulse.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= IDLE;
      wr_addr_q   <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      alu_en_q    <= 1'b0;
      alu_func_q  <= '0;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      alu_en_q    <= alu_en_d;
      alu_func_q  <= alu_func_d;
      dropped_q   <= dropped_d;
    end
  end

  assign reg_write_enable = reg_we_q;
  assign reg_read_enable  = reg_re_q;
  assign reg_address      = reg_addr_q;
  assign reg_write_data   = reg_wdata_q;
  assign alu_enable       = alu_en_q;
  assign alu_function     = alu_func_q;
  assign frame_dropped    = dropped_q;
  assign parser_busy      = busy;

endmodule

// File: tb/tb_uart_rx_command_parser.sv
// Directed bench for uart_rx_command_parser with TIMEOUT_CYCLES = 16.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// that follows the rising edge under test.
module tb_uart_rx_command_parser;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int FW = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_data_valid;
  logic [DW-1:0] rx_data;
  logic          rx_parity_error;
  logic          rx_frame_error;
  logic          reg_write_enable;
  logic          reg_read_enable;
  logic [AW-1:0] reg_address;
  logic [DW-1:0] reg_write_data;
  logic          alu_enable;
  logic [FW-1:0] alu_function;
  logic          frame_dropped;
  logic          parser_busy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_rx_command_parser #(
    .DATA_WIDTH        (DW),
    .ADDRESS_WIDTH     (AW),
    .ALU_FUNCTION_WIDTH(FW),
    .TIMEOUT_CYCLES    (TO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .rx_data_valid   (rx_data_valid),
    .rx_data         (rx_data),
    .rx_parity_error (rx_parity_error),
    .rx_frame_error  (rx_frame_error),
    .reg_write_enable(reg_write_enable),
    .reg_read_enable (reg_read_enable),
    .reg_address     (reg_address),
    .reg_write_data  (reg_write_data),
    .alu_enable      (alu_enable),
    .alu_function    (alu_function),
    .frame_dropped   (frame_dropped),
    .parser_busy     (parser_busy)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Called on a falling edge: presents one byte for one cycle and returns on
  // the next falling edge, where the strobes it triggers are visible.
  task automatic send_byte(input logic [DW-1:0] b, input logic pe = 1'b0,
                           input logic fe = 1'b0);
    rx_data_valid   = 1'b1;
    rx_data         = b;
    rx_parity_error = pe;
    rx_frame_error  = fe;
    @(negedge clk);
    rx_data_valid   = 1'b0;
    rx_parity_error = 1'b0;
    rx_frame_error  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset           = 1'b1;
    rx_data_valid   = 1'b0;
    rx_data         = '0;
    rx_parity_error = 1'b0;
    rx_frame_error  = 1'b0;
    idle(2);

    // Reset state
    check("rst_we",    reg_write_enable, 0);
    check("rst_re",    reg_read_enable,  0);
    check("rst_alu",   alu_enable,       0);
    check("rst_drop",  frame_dropped,    0);
    check("rst_busy",  parser_busy,      0);
    check("rst_addr",  reg_address,      0);
    check("rst_wdata", reg_write_data,   0);
    check("rst_func",  alu_function,     0);
    reset = 1'b0;
    idle(1);

    // Write frame AA,05,3C with bytes 10 cycles apart
    send_byte(8'hAA);
    check("wr_busy", parser_busy, 1);
    idle(9);
    send_byte(8'h05);
    check("wr_no_early_we", reg_write_enable, 0);
    idle(9);
    send_byte(8'h3C);
    check("wr_we",    reg_write_enable, 1);
    check("wr_addr",  reg_address,      5);
    check("wr_data",  reg_write_data,   8'h3C);
    check("wr_re",    reg_read_enable,  0);
    check("wr_drop",  frame_dropped,    0);
    idle(1);
    check("wr_we_1cyc",  reg_write_enable, 0);
    check("wr_busy_off", parser_busy,      0);
    check("wr_addr_hold", reg_address,     5);
    check("wr_data_hold", reg_write_data,  8'h3C);

    // ALU frame CC,12,34,07 then back-to-back DD,0A
    send_byte(8'hCC);
    send_byte(8'h12);
    check("aluA_we",   reg_write_enable, 1);
    check("aluA_addr", reg_address,      0);
    check("aluA_data", reg_write_data,   8'h12);
    idle(1);
    check("aluA_1cyc", reg_write_enable, 0);
    send_byte(8'h34);
    check("aluB_we",   reg_write_enable, 1);
    check("aluB_addr", reg_address,      1);
    check("aluB_data", reg_write_data,   8'h34);
    idle(1);
    check("aluB_1cyc", reg_write_enable, 0);
    send_byte(8'h07);
    check("alu_en",    alu_enable,       1);
    check("alu_func",  alu_function,     7);
    check("alu_no_we", reg_write_enable, 0);
    send_byte(8'hDD);
    check("alu_1cyc",  alu_enable,  0);
    check("b2b_busy",  parser_busy, 1);
    send_byte(8'h0A);
    check("b2b_alu_en",   alu_enable,   1);
    check("b2b_alu_func", alu_function, 4'hA);
    idle(1);

    // Read with out-of-range address, then a valid read
    send_byte(8'hBB);
    send_byte(8'hF3);
    check("rdbad_drop", frame_dropped,   1);
    check("rdbad_re",   reg_read_enable, 0);
    check("rdbad_busy", parser_busy,     0);
    idle(1);
    check("rdbad_drop_1cyc", frame_dropped, 0);
    send_byte(8'hBB);
    send_byte(8'h03);
    check("rd_re",   reg_read_enable, 1);
    check("rd_addr", reg_address,     3);
    check("rd_drop", frame_dropped,   0);
    idle(1);

    // Write address with upper bits set
    send_byte(8'hAA);
    send_byte(8'h1F);
    check("wabad_drop", frame_dropped, 1);
    check("wabad_busy", parser_busy,   0);
    idle(1);

    // Parity error on the data byte, then DD,01
    send_byte(8'hAA);
    send_byte(8'h02);
    send_byte(8'h55, 1'b1, 1'b0);
    check("perr_drop", frame_dropped,    1);
    check("perr_we",   reg_write_enable, 0);
    check("perr_busy", parser_busy,      0);
    send_byte(8'hDD);
    send_byte(8'h01);
    check("perr_next_alu",  alu_enable,   1);
    check("perr_next_func", alu_function, 1);
    idle(1);

    // Errored opcode in IDLE and a non-opcode byte are both ignored
    send_byte(8'hAA, 1'b0, 1'b1);
    check("idle_err_busy", parser_busy,   0);
    check("idle_err_drop", frame_dropped, 0);
    send_byte(8'h05);
    check("idle_junk_busy", parser_busy,   0);
    check("idle_junk_drop", frame_dropped, 0);
    idle(1);

    // Timeout: count reaches 16 at the 16th edge after the last byte's edge
    send_byte(8'hAA);
    send_byte(8'h04);
    for (int i = 1; i < TO; i++) begin
      idle(1);
      check($sformatf("to_wait_%0d", i), frame_dropped, 0);
    end
    check("to_busy_before", parser_busy, 1);
    idle(1);
    check("to_drop", frame_dropped,    1);
    check("to_we",   reg_write_enable, 0);
    check("to_busy", parser_busy,      0);
    idle(1);
    check("to_drop_1cyc", frame_dropped, 0);

    // Byte arriving in the expiry cycle is processed instead
    send_byte(8'hAA);
    send_byte(8'h04);
    idle(TO - 1);
    send_byte(8'h66);
    check("toedge_we",   reg_write_enable, 1);
    check("toedge_addr", reg_address,      4);
    check("toedge_data", reg_write_data,   8'h66);
    check("toedge_drop", frame_dropped,    0);
    idle(1);
    check("toedge_drop_after", frame_dropped, 0);

    // Asynchronous reset mid-frame
    send_byte(8'hAA);
    send_byte(8'h01);
    #1 reset = 1'b1;
    #1;
    check("mrst_busy",  parser_busy,      0);
    check("mrst_addr",  reg_address,      0);
    check("mrst_wdata", reg_write_data,   0);
    check("mrst_func",  alu_function,     0);
    check("mrst_we",    reg_write_enable, 0);
    @(negedge clk);
    reset = 1'b0;
    idle(1);
    check("mrst_no_drop", frame_dropped, 0);
    send_byte(8'h77);
    check("mrst_junk_busy", parser_busy, 0);
    send_byte(8'hAA);
    send_byte(8'h01);
    check("mrst_no_stale_we", reg_write_enable, 0);
    send_byte(8'h99);
    check("mrst_we2",   reg_write_enable, 1);
    check("mrst_addr2", reg_address,      1);
    check("mrst_data2", reg_write_data,   8'h99);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
